imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and assembles the bytes little-endian into 32-bit instruction words.
- Writes each word into instruction memory at sequential word addresses, then releases the CPU from reset.
- A 32'd0 word is the end-of-program marker. It is written to instruction memory, and loading then terminates.

Parameters:
MAX_WORDS, 256, instruction memory depth in 32-bit words; must be a power of 2 and at least 2
CNT_W, 9, width of word_count_o; must satisfy 2^CNT_W > MAX_WORDS

Ports:
clk_i  input  1  system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
start_i  input  1  begin a new load; single-cycle pulse
byte_i  input  8  stream byte
byte_valid_i  input  1  byte_i is valid this cycle
byte_ready_o  output  1  loader accepts byte_i this cycle
im_we_o  output  1  instruction memory write strobe, one cycle per word
im_addr_o  output  32  instruction memory byte address, word-aligned (bits [1:0] = 0)
im_wdata_o  output  32  instruction word to write
cpu_rst_n_o  output  1  active-low reset to the CPU; high only in RUN
done_o  output  1  load complete, CPU running
overflow_o  output  1  MAX_WORDS words loaded without an end marker
word_count_o  output  CNT_W  words written in current load, including the terminator

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE; all outputs 0 (cpu_rst_n_o=0, byte_ready_o=0, im_we_o=0, im_addr_o=0, im_wdata_o=0, done_o=0, overflow_o=0, word_count_o=0); byte counter and assembly register cleared. Instruction memory contents are not touched. rst_n dominates start_i and the handshake.
- All outputs are registered, except byte_ready_o, which is decoded from state: 1 only in LOAD.
- Transfer: a byte is transferred on a cycle with byte_valid_i=1 and byte_ready_o=1. Bytes presented while ready=0 are not consumed, and byte_i may change freely then.
- Byte order: the k-th accepted byte (k=0..3) of a word goes to bits [8k+7:8k].
- States: IDLE, LOAD, FINAL, RUN, ERR.
  - IDLE: ready=0, cpu_rst_n_o=0. On start_i, go to LOAD with word index 0, byte counter 0, done_o=0, overflow_o=0, word_count_o=0.
  - LOAD: ready=1. On the cycle T in which the 4th byte of a word is accepted, the following happens at T+1:
    - im_we_o=1 for exactly one cycle.
    - im_addr_o = word_index*4 and im_wdata_o = the assembled word.
    - word_count_o increments.
    - The byte counter and assembly register clear.
  - LOAD exit at T+1, decided by the word just completed:
    - Word == 0: go to FINAL.
    - Word != 0 and word_index == MAX_WORDS-1: go to ERR.
    - Otherwise stay in LOAD with word_index+1. Ready stays high, so back-to-back bytes assemble with no bubble.
  - FINAL: lasts exactly 1 cycle; this is the terminator write cycle; ready=0. Next state RUN.
  - RUN: cpu_rst_n_o=1 and done_o=1, both starting on the first RUN cycle, i.e. 2 cycles after the terminator's 4th byte is accepted. ready=0. On start_i: cpu_rst_n_o=0 and done_o=0 on the next cycle, then a new load starts as from IDLE.
  - ERR: overflow_o=1 from the cycle after the last write; ready=0; cpu_rst_n_o=0; done_o=0. Exit only via start_i (to LOAD, overflow_o cleared) or rst_n.
- start_i is ignored in LOAD and FINAL. A partial word is never discarded except by rst_n.
- Boundary: a terminator at word index MAX_WORDS-1 is legal and goes to FINAL, not ERR. word_count_o then equals MAX_WORDS.
- Address arithmetic: im_addr_o = {word_index, 2'b00}, zero-extended to 32 bits. There is no wrap-around, because ERR is entered first.

Test Plan:
- Stream 00 00 00 20, 00 00 00 00 (0x20000000, then terminator) back-to-back -> writes addr 0 data 0x20000000, then addr 4 data 0; cpu_rst_n_o=1 and done_o=1 exactly 2 cycles after the last byte; word_count_o=2.
- Same stream with byte_valid_i toggling 1/0 every cycle -> identical write sequence; no duplicated or lost bytes.
- Assert rst_n=0 after 2 bytes of word 1, then start_i and a fresh stream -> first write at addr 0 with new data; no stale bytes; all outputs 0 during reset.
- MAX_WORDS=4 with 4 non-zero words -> 4 writes (addr 0..12); overflow_o=1; cpu_rst_n_o stays 0; ready=0. Then start_i -> LOAD, overflow_o=0.
- MAX_WORDS=4 with 3 non-zero words plus terminator -> terminator written at addr 12; RUN; overflow_o=0; word_count_o=4.
- In RUN, pulse start_i -> cpu_rst_n_o falls next cycle and the reload restarts at addr 0. start_i pulsed during LOAD -> no effect on count or address.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes
// them to instruction memory and releases the CPU once a zero word is stored.
module imem_boot_loader #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             im_we_o,
    output logic [31:0]      im_addr_o,
    output logic [31:0]      im_wdata_o,
    output logic             cpu_rst_n_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] word_count_o
);
    localparam int IDX_W = $clog2(MAX_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FINAL = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;
    logic             accept, word_done, restart;
    logic [31:0]      word;

    assign byte_ready_o = (state == S_LOAD);
    assign accept       = byte_ready_o && byte_valid_i;
    assign word_done    = accept && (byte_cnt == 2'd3);
    // The fourth byte is merged on the fly so the word is written the very next cycle.
    assign word         = {byte_i, asm_q};
    assign restart      = (state_nxt == S_LOAD) && (state != S_LOAD);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: if (start_i) state_nxt = S_LOAD;
            S_LOAD: begin
                if (word_done) begin
                    if (word == 32'd0)
                        state_nxt = S_FINAL;
                    else if (word_idx == IDX_W'(MAX_WORDS - 1))
                        state_nxt = S_ERR;
                end
            end
            S_FINAL: state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            word_idx     <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            im_we_o      <= 1'b0;
            im_addr_o    <= '0;
            im_wdata_o   <= '0;
            cpu_rst_n_o  <= 1'b0;
            done_o       <= 1'b0;
            overflow_o   <= 1'b0;
            word_count_o <= '0;
        end else begin
            state       <= state_nxt;
            im_we_o     <= 1'b0;
            cpu_rst_n_o <= (state_nxt == S_RUN);
            done_o      <= (state_nxt == S_RUN);
            // Raised one cycle after entering ERR so it trails the last write.
            overflow_o  <= (state == S_ERR) && !start_i;

            if (restart) begin
                word_idx     <= '0;
                word_count_o <= '0;
            end

            if (accept) begin
                if (byte_cnt == 2'd3) begin
                    im_we_o      <= 1'b1;
                    im_addr_o    <= 32'({word_idx, 2'b00});
                    im_wdata_o   <= word;
                    word_count_o <= word_count_o + CNT_W'(1);
                    byte_cnt     <= '0;
                    asm_q        <= '0;
                    if (state_nxt == S_LOAD)
                        word_idx <= word_idx + IDX_W'(1);
                end else begin
                    case (byte_cnt)
                        2'd0:    asm_q[7:0]   <= byte_i;
                        2'd1:    asm_q[15:8]  <= byte_i;
                        default: asm_q[23:16] <= byte_i;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table vectors, a mid-load reset sequence and
// random streams checked against a word-level model of the load rules.
module tb_imem_boot_loader;
    localparam int MW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    bdata = 8'd0;
    logic          bvalid = 1'b0;
    logic          ready, we, cpu_rst_n, done, ovf;
    logic [31:0]   addr, wdata;
    logic [CW-1:0] count;

    imem_boot_loader #(.MAX_WORDS(MW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n(rst_n), .start_i(start), .byte_i(bdata),
        .byte_valid_i(bvalid), .byte_ready_o(ready), .im_we_o(we),
        .im_addr_o(addr), .im_wdata_o(wdata), .cpu_rst_n_o(cpu_rst_n),
        .done_o(done), .overflow_o(ovf), .word_count_o(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]       nw;
        logic [5:0][31:0] w;
        logic [1:0]       vmode;
        logic [2:0]       exp_wr;
        logic             exp_done;
        logic             exp_ovf;
    } vec_t;

    int          errors = 0, checks = 0;
    logic [31:0] sw[$];
    logic [7:0]  sb[$];
    logic [7:0]  acc_b[$];
    int          acc_c[$];
    logic [31:0] wr_a[$], wr_d[$];
    int          wr_c[$];
    int          done_c, ovf_c;
    bit          acc_flag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sample the cycle just before its rising edge, then move to just after it.
    task automatic step();
        @(negedge clk);
        acc_flag = bvalid && ready && rst_n;
        if (acc_flag) begin acc_b.push_back(bdata); acc_c.push_back(cyc); end
        if (we) begin wr_a.push_back(addr); wr_d.push_back(wdata); wr_c.push_back(cyc); end
        if (done && done_c < 0) done_c = cyc;
        if (ovf && ovf_c < 0) ovf_c = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        acc_b.delete(); acc_c.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        done_c = -1; ovf_c = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ovf"}, 32'(ovf), 0);
        chk({tag, "_count"}, 32'(count), 0);
    endtask

    // Word-level reference: words are stored in order until a zero word
    // (stored too) or until memory is full.
    task automatic model(output int ew, output bit dn, output bit ov);
        ew = 0; dn = 0;
        foreach (sw[i]) begin
            ew++;
            if (sw[i] == 32'd0) begin dn = 1; break; end
            if (ew == MW) break;
        end
        ov = !dn && (ew == MW);
    endtask

    task automatic run_load(input int vmode, input int exp_acc);
        int idx, stall, t;
        sb.delete();
        foreach (sw[i]) for (int k = 0; k < 4; k++) sb.push_back(sw[i][8*k +: 8]);
        start = 1'b1; step(); start = 1'b0;
        clear_rec();
        chk("start_ready", 32'(ready), 1);
        chk("start_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("start_done", 32'(done), 0);
        chk("start_ovf", 32'(ovf), 0);
        chk("start_count", 32'(count), 0);
        idx = 0; stall = 0; t = 0;
        while (idx < sb.size() && stall < 8 && t < 400) begin
            case (vmode)
                0:       bvalid = 1'b1;
                1:       bvalid = (t % 2 == 0);
                default: bvalid = 1'($urandom_range(0, 1));
            endcase
            bdata = bvalid ? sb[idx] : 8'($urandom);
            start = (vmode == 3) && (idx < exp_acc) && ($urandom_range(0, 3) == 0);
            step();
            t++;
            if (acc_flag) begin idx++; stall = 0; end
            else if (bvalid) stall++;
        end
        bvalid = 1'b0; start = 1'b0;
        repeat (4) step();
    endtask

    task automatic check_result(input int exp_wr, input bit exp_done, input bit exp_ovf);
        int bad, last;
        chk("n_writes", wr_a.size(), exp_wr);
        chk("n_bytes_accepted", acc_b.size(), exp_wr * 4);
        bad = 0;
        for (int j = 0; j < acc_b.size() && j < sb.size(); j++)
            if (acc_b[j] !== sb[j]) bad++;
        chk("byte_sequence_errs", bad, 0);
        for (int i = 0; i < wr_a.size() && i < exp_wr; i++) begin
            chk($sformatf("wr%0d_addr", i), wr_a[i], i * 4);
            chk($sformatf("wr%0d_data", i), wr_d[i], sw[i]);
            if (4*i + 3 < acc_c.size())
                chk($sformatf("wr%0d_latency", i), wr_c[i] - acc_c[4*i+3], 1);
        end
        chk("end_done", 32'(done), 32'(exp_done));
        chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'(exp_done));
        chk("end_ovf", 32'(ovf), 32'(exp_ovf));
        chk("end_count", 32'(count), exp_wr);
        chk("end_ready", 32'(ready), 0);
        last = exp_wr * 4 - 1;
        if (last >= 0 && last < acc_c.size()) begin
            if (exp_done) chk("done_latency", done_c - acc_c[last], 2);
            if (exp_ovf)  chk("ovf_latency", ovf_c - acc_c[last], 2);
        end
    endtask

    function automatic vec_t mk(input int nw, input logic [31:0] a, b, c, d, e, f,
                                input int vm, input int ew, input bit dn, input bit ov);
        vec_t v;
        v.nw = 3'(nw);
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
        v.vmode = 2'(vm); v.exp_wr = 3'(ew); v.exp_done = dn; v.exp_ovf = ov;
        return v;
    endfunction

    initial begin
        vec_t tv[7];
        int   ew;
        bit   dn, ov;

        tv[0] = mk(2, 32'h20000000, 0, 0, 0, 0, 0, 0, 2, 1, 0);
        tv[1] = mk(2, 32'h20000000, 0, 0, 0, 0, 0, 1, 2, 1, 0);
        tv[2] = mk(4, 32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000, 0, 0, 0, 4, 0, 1);
        tv[3] = mk(4, 32'hDEADBEEF, 32'h00FF0000, 32'h80000000, 0, 0, 0, 2, 4, 1, 0);
        tv[4] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        tv[5] = mk(5, 1, 2, 3, 4, 5, 0, 2, 4, 0, 1);
        tv[6] = mk(3, 32'h12345678, 32'h0000FF00, 0, 0, 0, 0, 3, 3, 1, 0);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(ready), 0);

        for (int i = 0; i < 7; i++) begin
            sw.delete();
            for (int j = 0; j < tv[i].nw; j++) sw.push_back(tv[i].w[j]);
            run_load(tv[i].vmode, tv[i].exp_wr * 4);
            check_result(tv[i].exp_wr, tv[i].exp_done, tv[i].exp_ovf);
        end

        // Reset in the middle of a word, with start and valid held high.
        start = 1'b1; step(); start = 1'b0;
        bvalid = 1'b1;
        foreach (sw[i]) sw.delete(i);
        begin
            logic [7:0] pre[6];
            pre = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h66, 8'h55};
            for (int k = 0; k < 6; k++) begin bdata = pre[k]; step(); end
        end
        rst_n = 1'b0; start = 1'b1;
        step();
        chk_all_zero("midreset");
        step();
        chk("midreset_hold_ready", 32'(ready), 0);
        rst_n = 1'b1; start = 1'b0; bvalid = 1'b0;
        step();
        chk("post_reset_ready", 32'(ready), 0);
        sw = '{32'hCAFEF00D, 32'h0};
        run_load(0, 8);
        check_result(2, 1, 0);

        for (int r = 0; r < 30; r++) begin
            int len;
            sw.delete();
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                logic [31:0] w;
                if ($urandom_range(0, 2) == 0) w = 32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3));
                else w = $urandom | 32'h1;
                sw.push_back(w);
            end
            if ($urandom_range(0, 1) == 1) sw[$urandom_range(0, len - 1)] = 32'h0;
            model(ew, dn, ov);
            if (!dn && !ov) begin
                sw.push_back(32'h0);
                model(ew, dn, ov);
            end
            run_load($urandom_range(0, 3), ew * 4);
            check_result(ew, dn, ov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
